// File: rtl/pin_target.sv
// pin_target: UART PIN responder; prompts ':', checks 4 PIN bytes, answers 'i' or 'O'.
// Optional lockout after MAX_FAIL consecutive misses is enabled by PIN_TARGET_LOCKOUT_EN.
module pin_target #(
  parameter int          CLKS_PER_BIT   = 104,
  parameter logic [31:0] SECRET_PIN     = 32'h34333231,
  parameter int          GAP_BITS       = 2,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        unlocked,
  output logic [15:0] attempts,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT * (GAP_BITS + 1) + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_BITS * CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [1:0] {TX_IDLE, TX_GAP, TX_FRAME} tx_t;
  typedef enum logic [2:0] {PROMPT, COLLECT, CHECK, SEND_FAIL, SEND_OK, DONE
`ifdef PIN_TARGET_LOCKOUT_EN
    , LOCKOUT
`endif
  } st_t;
  localparam tx_t TX_LOAD = (GAP_BITS == 0) ? TX_FRAME : TX_GAP;
  logic [2:0]    r_sync;
  rx_t           r_rx_st;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_valid;
  st_t           r_st;
  tx_t           r_ph;
  logic [CW-1:0] r_tcnt;
  logic [3:0]    r_tbit;
  logic [9:0]    r_tsh;
  logic [1:0]    r_idx;
  logic [31:0]   r_pin;
  logic          r_unl;
  logic [15:0]   r_att;
  logic          w_rx, w_fall, w_match, w_tx_done, w_lock, w_lock_end, w_go;
  logic [7:0]    w_byte;
  assign w_rx      = r_sync[1];
  assign w_fall    = r_sync[2] & ~r_sync[1];
  assign w_match   = r_pin == SECRET_PIN;
  assign w_tx_done = (r_ph == TX_FRAME) && (r_tbit == 4'd9) && (r_tcnt == BIT_END);
`ifdef PIN_TARGET_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  logic [FW-1:0] r_fail;
  logic [LW-1:0] r_lcnt;
  assign w_lock     = r_fail >= FW'(MAX_FAIL);
  assign w_lock_end = (r_st == LOCKOUT) && (r_lcnt == LW'(LOCKOUT_CYCLES - 1));
`else
  assign w_lock     = 1'b0;
  assign w_lock_end = 1'b0;
`endif
  assign w_go   = (r_st == CHECK) | ((r_st == SEND_FAIL) & w_tx_done & ~w_lock) | w_lock_end;
  assign w_byte = (r_st == CHECK) ? (w_match ? 8'h4f : 8'h69) : 8'h3a;
  assign tx       = (r_ph != TX_FRAME) | r_tsh[0];
  assign busy     = r_ph == TX_FRAME;
  assign unlocked = r_unl;
  assign attempts = r_att;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync     <= 3'b111;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_sync     <= {r_sync[1:0], rx};
      r_rx_valid <= 1'b0;
      case (r_rx_st)
        RX_IDLE: if (w_fall) begin
          r_rx_st  <= RX_START;
          r_rx_cnt <= '0;
        end
        RX_START: if (r_rx_cnt == HALF_END) begin
          r_rx_st  <= w_rx ? RX_IDLE : RX_DATA;
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        RX_DATA: if (r_rx_cnt == BIT_END) begin
          r_rx_cnt <= '0;
          r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
          r_rx_bit <= r_rx_bit + 1'b1;
          r_rx_st  <= (&r_rx_bit) ? RX_STOP : RX_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        default: if (r_rx_cnt == BIT_END) begin
          r_rx_st    <= RX_IDLE;
          r_rx_cnt   <= '0;
          r_rx_valid <= w_rx;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= PROMPT;
      r_ph   <= TX_LOAD;
      r_tcnt <= '0;
      r_tbit <= '0;
      r_tsh  <= {1'b1, 8'h3a, 1'b0};
      r_idx  <= '0;
      r_pin  <= '0;
      r_unl  <= 1'b0;
      r_att  <= '0;
`ifdef PIN_TARGET_LOCKOUT_EN
      r_fail <= '0;
      r_lcnt <= '0;
`endif
    end else begin
      if (w_go) begin
        r_ph   <= TX_LOAD;
        r_tcnt <= '0;
        r_tbit <= '0;
        r_tsh  <= {1'b1, w_byte, 1'b0};
      end else if (r_ph == TX_GAP) begin
        r_ph   <= (r_tcnt == GAP_END) ? TX_FRAME : TX_GAP;
        r_tcnt <= (r_tcnt == GAP_END) ? '0 : r_tcnt + 1'b1;
      end else if (r_ph == TX_FRAME) begin
        r_tcnt <= (r_tcnt == BIT_END) ? '0 : r_tcnt + 1'b1;
        if (r_tcnt == BIT_END) begin
          r_tsh  <= {1'b1, r_tsh[9:1]};
          r_tbit <= r_tbit + 1'b1;
          r_ph   <= (r_tbit == 4'd9) ? TX_IDLE : TX_FRAME;
        end
      end
      case (r_st)
        PROMPT: if (w_tx_done) r_st <= COLLECT;
        COLLECT: if (r_rx_valid) begin
          r_pin[{r_idx, 3'b000} +: 8] <= r_rx_sh;
          r_idx <= r_idx + 1'b1;
          if (&r_idx) r_st <= CHECK;
        end
        CHECK: begin
          r_att <= (&r_att) ? r_att : r_att + 16'd1;
          r_unl <= r_unl | w_match;
          r_st  <= w_match ? SEND_OK : SEND_FAIL;
`ifdef PIN_TARGET_LOCKOUT_EN
          r_fail <= w_match ? '0 : r_fail + 1'b1;
`endif
        end
        SEND_FAIL: if (w_tx_done) begin
`ifdef PIN_TARGET_LOCKOUT_EN
          r_st   <= w_lock ? LOCKOUT : PROMPT;
          r_lcnt <= '0;
`else
          r_st <= PROMPT;
`endif
        end
        SEND_OK: if (w_tx_done) r_st <= DONE;
`ifdef PIN_TARGET_LOCKOUT_EN
        LOCKOUT: if (w_lock_end) begin
          r_fail <= '0;
          r_st   <= PROMPT;
        end else r_lcnt <= r_lcnt + 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule
